// File: rtl/ram_dp_param.sv
// Simple dual-port synchronous RAM: byte-masked write port, registered read port,
// selectable read-during-write behaviour, optional output register and post-reset clear.
module ram_dp_param #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6,
  parameter int RD_MODE    = 0,
  parameter int OUT_REG    = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_enable,
  input  logic [ADDR_WIDTH-1:0]     wr_adress,
  input  logic [DATA_WIDTH/8-1:0]   wr_byte_en,
  input  logic [DATA_WIDTH-1:0]     data_in,
  input  logic                      rd_enable,
  input  logic [ADDR_WIDTH-1:0]     rd_adress,
  output logic [DATA_WIDTH-1:0]     data_out,
  output logic                      rd_valid,
  output logic                      init_busy
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int BYTES = DATA_WIDTH/8;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   init_cnt;
  logic                    init_last;
  logic                    run;
  logic                    wr_run_p0;
  logic                    rd_run_p0;
  logic [DATA_WIDTH-1:0]   rd_word_p0;
  logic [DATA_WIDTH-1:0]   rd_data_p1;
  logic                    vld_p1;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] new_w,
    input logic [BYTES-1:0]      be
  );
    merge_bytes = old_w;
    for (int k = 0; k < BYTES; k++)
      if (be[k]) merge_bytes[8*k +: 8] = new_w[8*k +: 8];
  endfunction

  assign init_last = (init_cnt == ADDR_WIDTH'(DEPTH-1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_INIT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: if (init_last) state_nxt = ST_RUN;
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_INIT;
    endcase
  end

  always_comb begin
    init_busy = 1'b0;
    run       = 1'b0;
    case (state)
      ST_INIT: init_busy = 1'b1;
      ST_RUN:  run       = 1'b1;
      default: init_busy = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         init_cnt <= '0;
    else if (init_busy) init_cnt <= init_cnt + ADDR_WIDTH'(1);
  end

  // ---- stage p0: request qualification and array access ----
  assign wr_run_p0 = run & wr_enable;
  assign rd_run_p0 = run & rd_enable;

  always_ff @(posedge clk) begin
    if (init_busy) begin
      mem[init_cnt] <= '0;
    end else if (wr_run_p0) begin
      for (int k = 0; k < BYTES; k++)
        if (wr_byte_en[k]) mem[wr_adress][8*k +: 8] <= data_in[8*k +: 8];
    end
  end

  // Write-first forwards the merged word; read-first relies on the array's pre-edge value.
  always_comb begin
    rd_word_p0 = mem[rd_adress];
    if (RD_MODE != 0 && wr_run_p0 && (wr_adress == rd_adress))
      rd_word_p0 = merge_bytes(mem[rd_adress], data_in, wr_byte_en);
  end

  // ---- stage p1: registered read data ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_p1 <= '0;
      vld_p1     <= 1'b0;
    end else begin
      vld_p1 <= rd_run_p0;
      if (rd_run_p0) rd_data_p1 <= rd_word_p0;
    end
  end

  // ---- stage p2: optional output register ----
  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] rd_data_p2;
      logic                  vld_p2;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          rd_data_p2 <= '0;
          vld_p2     <= 1'b0;
        end else begin
          vld_p2 <= vld_p1;
          if (vld_p1) rd_data_p2 <= rd_data_p1;
        end
      end

      assign data_out = rd_data_p2;
      assign rd_valid = vld_p2;
    end else begin : g_no_out_reg
      assign data_out = rd_data_p1;
      assign rd_valid = vld_p1;
    end
  endgenerate

endmodule

// File: tb/tb_ram_dp_param.sv
// Directed bench for ram_dp_param: instance a (read-first, latency 1) and
// instance b (write-first, latency 2) share the same stimulus.
module tb_ram_dp_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_enable;
  logic [5:0]  wr_adress;
  logic [1:0]  wr_byte_en;
  logic [15:0] data_in;
  logic        rd_enable;
  logic [5:0]  rd_adress;
  logic [15:0] data_out_a, data_out_b;
  logic        rd_valid_a, rd_valid_b;
  logic        init_busy_a, init_busy_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_dp_param #(.DATA_WIDTH(16), .ADDR_WIDTH(6), .RD_MODE(0), .OUT_REG(0)) dut_a (
    .clk(clk), .reset(reset),
    .wr_enable(wr_enable), .wr_adress(wr_adress), .wr_byte_en(wr_byte_en), .data_in(data_in),
    .rd_enable(rd_enable), .rd_adress(rd_adress),
    .data_out(data_out_a), .rd_valid(rd_valid_a), .init_busy(init_busy_a)
  );

  ram_dp_param #(.DATA_WIDTH(16), .ADDR_WIDTH(6), .RD_MODE(1), .OUT_REG(1)) dut_b (
    .clk(clk), .reset(reset),
    .wr_enable(wr_enable), .wr_adress(wr_adress), .wr_byte_en(wr_byte_en), .data_in(data_in),
    .rd_enable(rd_enable), .rd_adress(rd_adress),
    .data_out(data_out_b), .rd_valid(rd_valid_b), .init_busy(init_busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy_a"}, 32'(init_busy_a), 32'd1);
    chk({tag, "_busy_b"}, 32'(init_busy_b), 32'd1);
    chk({tag, "_vld_a"},  32'(rd_valid_a),  32'd0);
    chk({tag, "_vld_b"},  32'(rd_valid_b),  32'd0);
    chk({tag, "_dout_a"}, 32'(data_out_a),  32'h0);
    chk({tag, "_dout_b"}, 32'(data_out_b),  32'h0);
  endtask

  // Counts edges from reset release until init_busy falls; flags any rd_valid seen.
  task automatic wait_init(input string tag);
    int n;
    int stray;
    n = 0;
    stray = 0;
    do begin
      step();
      n++;
      if (rd_valid_a || rd_valid_b) stray++;
    end while (init_busy_a && n < 200);
    chk({tag, "_len"},    32'(n),           32'd64);
    chk({tag, "_busy_b"}, 32'(init_busy_b), 32'd0);
    chk({tag, "_stray"},  32'(stray),       32'd0);
  endtask

  task automatic wr(input logic [5:0] a, input logic [15:0] d, input logic [1:0] be);
    wr_enable  = 1'b1;
    wr_adress  = a;
    data_in    = d;
    wr_byte_en = be;
    step();
    wr_enable  = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [5:0] a,
                        input logic [15:0] exp_a, input logic [15:0] exp_b);
    rd_enable = 1'b1;
    rd_adress = a;
    step();
    rd_enable = 1'b0;
    chk({tag, "_vld_a"},  32'(rd_valid_a), 32'd1);
    chk({tag, "_dout_a"}, 32'(data_out_a), 32'(exp_a));
    chk({tag, "_early_b"}, 32'(rd_valid_b), 32'd0);
    step();
    chk({tag, "_vld_b"},  32'(rd_valid_b), 32'd1);
    chk({tag, "_dout_b"}, 32'(data_out_b), 32'(exp_b));
    chk({tag, "_drop_a"}, 32'(rd_valid_a), 32'd0);
  endtask

  initial begin
    reset      = 1'b0;
    wr_enable  = 1'b0;
    wr_adress  = '0;
    wr_byte_en = '0;
    data_in    = '0;
    rd_enable  = 1'b0;
    rd_adress  = '0;

    repeat (3) step();
    check_reset_outputs("rst");

    // Requests held active through the whole init window must be ignored.
    wr_enable  = 1'b1;
    wr_adress  = 6'd3;
    data_in    = 16'hBEEF;
    wr_byte_en = 2'b11;
    rd_enable  = 1'b1;
    rd_adress  = 6'd3;
    reset      = 1'b1;
    wait_init("init");
    wr_enable  = 1'b0;
    rd_enable  = 1'b0;
    step();
    chk("post_init_vld_a", 32'(rd_valid_a), 32'd0);
    rd_chk("rd37", 6'd37, 16'h0000, 16'h0000);
    rd_chk("rd3",  6'd3,  16'h0000, 16'h0000);

    // Fill then back-to-back readback.
    for (int i = 0; i < 64; i++) wr(6'(i), 16'(16'h7F80 + i), 2'b11);
    for (int i = 0; i < 66; i++) begin
      rd_enable = (i < 64);
      rd_adress = 6'(i);
      step();
      if (i < 64) begin
        chk("fill_vld_a",  32'(rd_valid_a), 32'd1);
        chk("fill_dout_a", 32'(data_out_a), 32'(16'h7F80 + i));
      end else begin
        chk("fill_end_a",  32'(rd_valid_a), 32'd0);
      end
      if (i >= 1 && i <= 64) begin
        chk("fill_vld_b",  32'(rd_valid_b), 32'd1);
        chk("fill_dout_b", 32'(data_out_b), 32'(16'h7F80 + i - 1));
      end else begin
        chk("fill_idle_b", 32'(rd_valid_b), 32'd0);
      end
    end
    rd_enable = 1'b0;
    chk("hold_dout_a", 32'(data_out_a), 32'h7FBF);
    chk("hold_dout_b", 32'(data_out_b), 32'h7FBF);

    // Byte enables.
    wr(6'd5, 16'hAAAA, 2'b11);
    wr(6'd5, 16'h1234, 2'b01);
    wr(6'd5, 16'hFFFF, 2'b00);
    rd_chk("be5", 6'd5, 16'hAA34, 16'hAA34);

    // Same-address collision.
    wr(6'd9, 16'h1111, 2'b11);
    wr_enable  = 1'b1;
    wr_adress  = 6'd9;
    data_in    = 16'h2222;
    wr_byte_en = 2'b11;
    rd_enable  = 1'b1;
    rd_adress  = 6'd9;
    step();
    wr_enable  = 1'b0;
    rd_enable  = 1'b0;
    chk("coll_dout_a", 32'(data_out_a), 32'h1111);
    step();
    chk("coll_vld_b",  32'(rd_valid_b), 32'd1);
    chk("coll_dout_b", 32'(data_out_b), 32'h2222);
    rd_chk("coll_after", 6'd9, 16'h2222, 16'h2222);

    // Write-first merge with a partial mask.
    wr(6'd12, 16'h1111, 2'b11);
    wr_enable  = 1'b1;
    wr_adress  = 6'd12;
    data_in    = 16'hABCD;
    wr_byte_en = 2'b10;
    rd_enable  = 1'b1;
    rd_adress  = 6'd12;
    step();
    wr_enable  = 1'b0;
    rd_enable  = 1'b0;
    chk("pcoll_dout_a", 32'(data_out_a), 32'h1111);
    step();
    chk("pcoll_dout_b", 32'(data_out_b), 32'hAB11);

    // Different-address write and read on the same edge.
    wr_enable  = 1'b1;
    wr_adress  = 6'd10;
    data_in    = 16'h5555;
    wr_byte_en = 2'b11;
    rd_enable  = 1'b1;
    rd_adress  = 6'd11;
    step();
    wr_enable  = 1'b0;
    rd_enable  = 1'b0;
    chk("diff_dout_a", 32'(data_out_a), 32'h7F8B);
    step();
    chk("diff_dout_b", 32'(data_out_b), 32'h7F8B);
    rd_chk("diff_rd10", 6'd10, 16'h5555, 16'h5555);

    // Reset with a read in flight.
    rd_enable = 1'b1;
    rd_adress = 6'd20;
    step();
    rd_enable = 1'b0;
    chk("inflight_dout_a", 32'(data_out_a), 32'h7F94);
    reset = 1'b0;
    #1;
    check_reset_outputs("rst_rd");
    step();
    chk("rst_rd_flush_b", 32'(rd_valid_b), 32'd0);
    step();
    reset = 1'b1;
    wait_init("reinit_rd");
    step();
    chk("reinit_rd_vld_a", 32'(rd_valid_a), 32'd0);
    chk("reinit_rd_vld_b", 32'(rd_valid_b), 32'd0);
    rd_chk("rd20_cleared", 6'd20, 16'h0000, 16'h0000);

    // Reset during the 10th init cycle.
    reset = 1'b0;
    step();
    reset = 1'b1;
    repeat (9) step();
    chk("mid_init_busy", 32'(init_busy_a), 32'd1);
    reset = 1'b0;
    #1;
    check_reset_outputs("rst_init");
    step();
    reset = 1'b1;
    wait_init("reinit_mid");
    rd_chk("rd63_cleared", 6'd63, 16'h0000, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ram_dp_param.md
# ram_dp_param

Parametrised simple dual-port synchronous RAM, the successor to the fixed 64x16 RAM. It adds configurable width and depth, per-byte write enables, a selectable read-during-write mode and an optional output register. A self-clearing init sequencer zeroes every word after reset. It sits as the general-purpose storage primitive behind FIFOs and buffers in the design, with one write port and one read port on a single clock.

## Interface
- DATA_WIDTH, 16, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 6, address width; DEPTH = 2**ADDR_WIDTH words (derived, not overridable).
- RD_MODE, 0, same-address read/write collision: 0 = read-first (old word), 1 = write-first (merged new word).
- OUT_REG, 0, 0 = read latency 1 cycle, 1 = extra output register, latency 2 cycles.
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_enable  in  1  write request, sampled at rising clk.
- wr_adress  in  ADDR_WIDTH  write address.
- wr_byte_en  in  DATA_WIDTH/8  per-byte write mask; bit k covers data_in[8k+7:8k].
- data_in  in  DATA_WIDTH  write data.
- rd_enable  in  1  read request, sampled at rising clk.
- rd_adress  in  ADDR_WIDTH  read address.
- data_out  out  DATA_WIDTH  read data.
- rd_valid  out  1  one-cycle strobe, data_out carries the requested word.
- init_busy  out  1  high while the clear sequencer runs; requests are ignored.

## Operation
- Reset asserted (reset=0): init_busy=1, rd_valid=0, data_out=0, and the output register (if present) is 0. These values hold asynchronously. The FSM enters INIT and the init counter is set to 0.
- FSM states:
  - INIT: each rising edge writes 0 to mem[cnt] and increments cnt. On the edge that writes DEPTH-1, go to RUN and set init_busy=0.
  - RUN: normal operation. No other states.
- In INIT, wr_enable and rd_enable are ignored: no array write from the ports, and rd_valid stays 0.
- Write (RUN, wr_enable=1): for each byte k with wr_byte_en[k]=1, mem[wr_adress] byte k takes data_in byte k. Other bytes are unchanged. A mask of all zeros is a no-op.
- Read (RUN, rd_enable=1): returns mem[rd_adress] on data_out and pulses rd_valid.
- Collision (rd_enable and wr_enable both 1, rd_adress == wr_adress, same edge):
  - RD_MODE=0: returns the pre-write word.
  - RD_MODE=1: returns the post-write word, i.e. new bytes where the mask is set and old bytes elsewhere.
  - The array is updated in both modes.
- Different-address simultaneous read and write: independent, no interaction.
- No read issued: data_out holds its last value and rd_valid=0.
- Back-to-back reads every cycle are supported: full throughput, one result per cycle.

## Timing
- Reads, OUT_REG=0: rd_enable sampled at edge N. data_out and rd_valid update at edge N (registered), valid during cycle N..N+1.
- Reads, OUT_REG=1: same, but delayed to edge N+1. rd_valid is pipelined alongside the data.
- Writes: take effect at the sampling edge and are visible to a read sampled on the next edge, or on the same edge per RD_MODE.
- Init: after reset release, the first rising edge clears address 0. init_busy falls on the DEPTH-th edge, so it is high for exactly DEPTH cycles. Requests sampled on the edge where init_busy falls are still ignored.
- Reset mid-INIT: the sequencer restarts at address 0.
- Reset mid-read: in-flight reads are flushed, with no rd_valid after reset release.
- Reset does not otherwise clear the array; clearing is done only by the sequencer.

## Test plan
- Reset/init (defaults): hold reset=0 for 3 cycles, then release. Required: data_out=0, rd_valid=0, init_busy=1 during reset. init_busy is high for 64 edges and then 0. A read of any address, e.g. 6'd37, returns 16'h0000.
- Fill and readback: write 16'h7F80 + i to address i for i=0..63 with wr_byte_en=2'b11, then read 0..63 back-to-back. Required: rd_valid every cycle and data_out = 16'h7F80 + i with 1-cycle latency (2 cycles with OUT_REG=1).
- Byte enables: write 16'hAAAA to addr 5, then 16'h1234 with wr_byte_en=2'b01, then 2'b00 with 16'hFFFF. Read addr 5 → 16'hAA34.
- Collision: addr 9 holds 16'h1111. On the same edge, write 16'h2222 (mask 2'b11) and read addr 9. Required: RD_MODE=0 → 16'h1111, RD_MODE=1 → 16'h2222. A following read of addr 9 returns 16'h2222 in both modes.
- Ignored during init: assert wr_enable (addr 3, 16'hBEEF) and rd_enable during INIT. Required: rd_valid=0, and a read of addr 3 after init returns 16'h0000.
- Reset mid-operation: pull reset low during the 10th init cycle, and separately with a read in flight. Required: outputs return to 0 immediately, the sequencer restarts at address 0 with a full 64-cycle init_busy, and no stray rd_valid appears.
